// File: rtl/ram_rd_buf_if.sv
// ram_rd_buf_if: bundles the read-stage control/return signals and the
// consumer ready/valid stream of ram_rd_buf.
// master = the buffer side, slave = read stage plus consumer side.
interface ram_rd_buf_if #(
   parameter int WIDTH = 32
) ();
   logic             o_read;
   logic             o_addressing;
   logic             o_term;
   logic [WIDTH-1:0] o_rd_addr;
   logic [WIDTH-1:0] i_ram_data;
   logic             i_ram_valid;
   logic [WIDTH-1:0] o_data;
   logic             o_valid;
   logic             i_ready;

   modport master (
      output o_read, o_addressing, o_term, o_rd_addr, o_data, o_valid,
      input  i_ram_data, i_ram_valid, i_ready
   );

   modport slave (
      input  o_read, o_addressing, o_term, o_rd_addr, o_data, o_valid,
      output i_ram_data, i_ram_valid, i_ready
   );
endinterface

// File: rtl/ram_rd_buf.sv
// ram_rd_buf: sequences the RAM read stage (load/stream/pause/terminate),
// captures the returned words into a first-word-fall-through FIFO and hands
// them to the consumer. Backpressure pauses reading and re-addresses at
// base+cap on resume, since the read stage cannot be stalled.
// Optional overflow flag o_err is built only when RD_BUF_ERR_EN is defined.
module ram_rd_buf #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int LAT   = 1
) (
   input  logic             i_clk,
   input  logic             i_n_reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_base,
   input  logic [WIDTH-1:0] i_len,
   ram_rd_buf_if.master     bus,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int WW = $clog2(LAT + 2) + 1;
   localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);
   localparam logic [LW-1:0] PAUSE_AT   = LW'(LAT + 1);
   localparam logic [LW-1:0] RESUME_AT  = LW'(LAT + 2);
   localparam logic [WW-1:0] FLUSH_WAIT = WW'(LAT + 1);
   // Words may still land during the first LAT-1 pause cycles without a gap.
   localparam logic [WW-1:0] PAUSE_WAIT = WW'(LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_STREAM, S_PAUSE, S_FLUSH, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] base_q, base_d, len_q, len_d, cap_q, cap_d;
   logic [WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [WW-1:0]    wait_q, wait_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    lvl_q, lvl_d;
   logic             read_q, read_d, addressing_q, addressing_d;
   logic             term_q, term_d, busy_q, busy_d, done_q, done_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic          empty, full, pop, push, cap_try;
   logic [LW-1:0] free;

   assign empty   = (lvl_q == '0);
   assign full    = (lvl_q == LVL_FULL);
   assign free    = LVL_FULL - lvl_q;
   assign pop     = !empty && bus.i_ready;
   // Capture is open while a fetch is live and the requested count is not met.
   assign cap_try = ((state_q == S_LOAD) || (state_q == S_STREAM) || (state_q == S_PAUSE))
                    && bus.i_ram_valid && (cap_q < len_q);
   assign push    = cap_try && (!full || pop);

   // Next-state, counters, FIFO pointers and registered control outputs.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      len_d     = len_q;
      cap_d     = cap_q;
      wait_d    = wait_q;
      rd_addr_d = rd_addr_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      lvl_d     = lvl_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         cap_d    = cap_q + WIDTH'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      lvl_d = lvl_q + LW'(1);
      else if (!push && pop) lvl_d = lvl_q - LW'(1);

      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               base_d    = i_base;
               len_d     = i_len;
               cap_d     = '0;
               rd_addr_d = i_base;
               state_d   = (i_len == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: state_d = S_STREAM;
         S_STREAM: begin
            if (cap_d == len_q) begin
               state_d = S_FLUSH;
               wait_d  = FLUSH_WAIT;
            end else if (free <= PAUSE_AT) begin
               state_d = S_PAUSE;
               wait_d  = PAUSE_WAIT;
            end
         end
         S_PAUSE: begin
            // In-flight words can complete the transfer while paused.
            if (cap_d == len_q) begin
               state_d = S_FLUSH;
               wait_d  = FLUSH_WAIT;
            end else if (wait_q != '0) begin
               wait_d = wait_q - WW'(1);
            end else if (!bus.i_ram_valid && (free >= RESUME_AT)) begin
               state_d   = S_LOAD;
               rd_addr_d = base_q + cap_q;
            end
         end
         S_FLUSH: begin
            if (wait_q == '0) state_d = S_DONE;
            else              wait_d  = wait_q - WW'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      read_d       = (state_d == S_LOAD) || (state_d == S_STREAM);
      addressing_d = (state_d == S_LOAD);
      term_d       = (state_d == S_FLUSH) && (state_q != S_FLUSH);
      busy_d       = (state_d != S_IDLE);
      done_d       = (state_q == S_DONE);
   end

   // Control state and registered outputs, synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_n_reset) begin
         state_q      <= S_IDLE;
         cap_q        <= '0;
         wait_q       <= '0;
         rd_addr_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         lvl_q        <= '0;
         read_q       <= 1'b0;
         addressing_q <= 1'b0;
         term_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cap_q        <= cap_d;
         wait_q       <= wait_d;
         rd_addr_q    <= rd_addr_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         lvl_q        <= lvl_d;
         read_q       <= read_d;
         addressing_q <= addressing_d;
         term_q       <= term_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // Transfer operands are only consumed after a start, so they need no reset.
   always_ff @(posedge i_clk) begin
      base_q <= base_d;
      len_q  <= len_d;
   end

   // FIFO storage write port.
   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.i_ram_data;
   end

`ifdef RD_BUF_ERR_EN
   logic err_q, err_d;

   // Sticky overflow: a capture into a full, non-draining FIFO; cleared by a new start.
   always_comb begin
      err_d = err_q;
      if ((state_q == S_IDLE) && i_start) err_d = 1'b0;
      else if (cap_try && full && !pop)   err_d = 1'b1;
   end

   // Overflow flag register.
   always_ff @(posedge i_clk) begin
      if (!i_n_reset) err_q <= 1'b0;
      else            err_q <= err_d;
   end

   assign o_err = err_q;
`else
   assign o_err = 1'b0;
`endif

   assign bus.o_read       = read_q;
   assign bus.o_addressing = addressing_q;
   assign bus.o_term       = term_q;
   assign bus.o_rd_addr    = rd_addr_q;
   assign bus.o_valid      = !empty;
   assign bus.o_data       = empty ? '0 : mem_q[rd_ptr_q];
   assign o_busy           = busy_q;
   assign o_done           = done_q;
endmodule
